// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: core datapath width and the
// RV32 load funct3 encodings consumed by the load aligner.
package wb_stage_pkg;

  // Core-wide datapath width.
  localparam int CORE_XLEN = 32;

  // Load type encodings (funct3 of LOAD instructions).
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

endpackage : wb_stage_pkg

// File: rtl/wb_stage_load_align.sv
// load_align: selects the addressed byte/halfword lane of an aligned load
// word and sign- or zero-extends it. Purely combinational; also used by the
// LSU misaligned-access checker.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select and extension; halfword lane uses only byte_off[1] since
  // misaligned halfwords never reach this point.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch can never be inferred.
    data     = word;
    byte_sel = word[{byte_off, 3'b000} +: 8];
    half_sel = word[{byte_off[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = word;  // LW and undefined encodings pass the word through
    endcase
  end

endmodule : load_align

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the rv32im core. Merges in-order pipeline
// results with out-of-band divider results onto the single regfile write
// port, with a starvation guard for the divider and a 64-bit instret counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN         = CORE_XLEN,
  parameter int DIV_MAX_WAIT = 4   // must be >= 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // memory-stage entry
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_rd_we_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic            mem_is_load_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [1:0]      mem_byte_off_i,
  input  logic [XLEN-1:0] mem_load_data_i,
  // divider result
  input  logic            div_valid_i,
  output logic            div_ready_o,
  input  logic [4:0]      div_rd_addr_i,
  input  logic [XLEN-1:0] div_result_i,
  // regfile write port
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_we_o,
  output logic [63:0]     instret_o
);

  localparam int WCW = $clog2(DIV_MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(DIV_MAX_WAIT);

  logic [WCW-1:0]  wait_cnt;
  logic            div_force;
  logic            mem_xfer;
  logic            div_xfer;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] mem_data;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3   (mem_funct3_i),
    .byte_off (mem_byte_off_i),
    .word     (mem_load_data_i),
    .data     (load_data)
  );

  // Arbitration: mem has priority until the divider has waited DIV_MAX_WAIT
  // cycles. With neither side valid both readies idle high; whenever any
  // valid is asserted exactly one ready is high.
  always_comb begin
    div_force   = div_valid_i && (wait_cnt >= WAIT_MAX);
    mem_ready_o = !div_valid_i || (mem_valid_i && !div_force);
    div_ready_o = !mem_valid_i || (div_valid_i && div_force);
    mem_xfer    = mem_valid_i && mem_ready_o;
    div_xfer    = div_valid_i && div_ready_o;
    mem_data    = mem_is_load_i ? load_data : mem_result_i;
  end

  // Starvation counter: counts cycles a pending divider result loses,
  // saturates at DIV_MAX_WAIT, clears when the divider result is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (div_xfer) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      wait_cnt <= '0;
    end else if (div_valid_i && !div_ready_o && (wait_cnt < WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Output register: one cycle after a transfer; writes to x0 suppressed.
  // Address/data hold when nothing transfers, only the write enable drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the output register is reset so the regfile sees a clean
      // no-write state immediately; a pending result is simply dropped.
      rd_addr_o <= '0;
      rd_data_o <= '0;
      rd_we_o   <= 1'b0;
    end else if (mem_xfer) begin
      rd_addr_o <= mem_rd_addr_i;
      rd_data_o <= mem_data;
      rd_we_o   <= mem_rd_we_i && (mem_rd_addr_i != 5'd0);
    end else if (div_xfer) begin
      rd_addr_o <= div_rd_addr_i;
      rd_data_o <= div_result_i;
      rd_we_o   <= (div_rd_addr_i != 5'd0);
    end else begin
      rd_we_o   <= 1'b0;
    end
  end

  // Retired-instruction counter: every mem transfer retires one instruction;
  // divider results belong to already-retired instructions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_o <= '0;
    end else if (mem_xfer) begin
      instret_o <= instret_o + 64'd1;
    end
  end

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (XLEN=32, DIV_MAX_WAIT=4).
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [4:0]  mem_rd_addr_i;
  logic        mem_rd_we_i;
  logic [31:0] mem_result_i;
  logic        mem_is_load_i;
  logic [2:0]  mem_funct3_i;
  logic [1:0]  mem_byte_off_i;
  logic [31:0] mem_load_data_i;
  logic        div_valid_i;
  logic        div_ready_o;
  logic [4:0]  div_rd_addr_i;
  logic [31:0] div_result_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_we_o;
  logic [63:0] instret_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_instret;

  wb_stage #(.XLEN(32), .DIV_MAX_WAIT(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .mem_valid_i     (mem_valid_i),
    .mem_ready_o     (mem_ready_o),
    .mem_rd_addr_i   (mem_rd_addr_i),
    .mem_rd_we_i     (mem_rd_we_i),
    .mem_result_i    (mem_result_i),
    .mem_is_load_i   (mem_is_load_i),
    .mem_funct3_i    (mem_funct3_i),
    .mem_byte_off_i  (mem_byte_off_i),
    .mem_load_data_i (mem_load_data_i),
    .div_valid_i     (div_valid_i),
    .div_ready_o     (div_ready_o),
    .div_rd_addr_i   (div_rd_addr_i),
    .div_result_i    (div_result_i),
    .rd_addr_o       (rd_addr_o),
    .rd_data_o       (rd_data_o),
    .rd_we_o         (rd_we_o),
    .instret_o       (instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mem_drive(input logic [4:0] rd, input logic we, input logic [31:0] res,
                           input logic ld, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] word);
    mem_valid_i     = 1'b1;
    mem_rd_addr_i   = rd;
    mem_rd_we_i     = we;
    mem_result_i    = res;
    mem_is_load_i   = ld;
    mem_funct3_i    = f3;
    mem_byte_off_i  = off;
    mem_load_data_i = word;
  endtask

  // One mem transfer starting just after a posedge; checks the write a cycle later.
  task automatic mem_xfer_check(input string tag, input logic [4:0] rd, input logic we,
                                input logic [31:0] res, input logic ld, input logic [2:0] f3,
                                input logic [1:0] off, input logic [31:0] word,
                                input logic exp_we, input logic [31:0] exp_data);
    mem_drive(rd, we, res, ld, f3, off, word);
    #1 check({tag, "_rdy"}, 64'(mem_ready_o), 64'd1);
    @(posedge clk_i); #1;
    mem_valid_i = 1'b0;
    exp_instret = exp_instret + 64'd1;
    check({tag, "_we"},   64'(rd_we_o),   64'(exp_we));
    check({tag, "_addr"}, 64'(rd_addr_o), 64'(rd));
    check({tag, "_data"}, 64'(rd_data_o), 64'(exp_data));
    check({tag, "_ret"},  instret_o,      exp_instret);
  endtask

  initial begin
    rst_ni = 1'b0;
    mem_valid_i = 1'b0; mem_rd_addr_i = '0; mem_rd_we_i = 1'b0; mem_result_i = '0;
    mem_is_load_i = 1'b0; mem_funct3_i = '0; mem_byte_off_i = '0; mem_load_data_i = '0;
    div_valid_i = 1'b0; div_rd_addr_i = '0; div_result_i = '0;
    exp_instret = '0;

    // Reset state
    #2;
    check("rst_we",   64'(rd_we_o),   64'd0);
    check("rst_addr", 64'(rd_addr_o), 64'd0);
    check("rst_data", 64'(rd_data_o), 64'd0);
    check("rst_ret",  instret_o,      64'd0);
    check("rst_wcnt", 64'(dut.wait_cnt), 64'd0);
    check("idle_mrdy", 64'(mem_ready_o), 64'd1);
    check("idle_drdy", 64'(div_ready_o), 64'd1);
    @(posedge clk_i); @(posedge clk_i); #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Load extension / lane select
    mem_xfer_check("lb2",  5'd5, 1'b1, 32'h0, 1'b1, F3_LB,  2'd2, 32'h1280_3456, 1'b1, 32'hFFFF_FF80);
    mem_xfer_check("lbu2", 5'd6, 1'b1, 32'h0, 1'b1, F3_LBU, 2'd2, 32'h1280_3456, 1'b1, 32'h0000_0080);
    mem_xfer_check("lh2",  5'd7, 1'b1, 32'h0, 1'b1, F3_LH,  2'd2, 32'h1280_3456, 1'b1, 32'h0000_1280);
    mem_xfer_check("lh0",  5'd8, 1'b1, 32'h0, 1'b1, F3_LH,  2'd1, 32'h1280_B456, 1'b1, 32'hFFFF_B456);
    mem_xfer_check("lhu2", 5'd9, 1'b1, 32'h0, 1'b1, F3_LHU, 2'd2, 32'hF00D_0000, 1'b1, 32'h0000_F00D);
    mem_xfer_check("lb3",  5'd10, 1'b1, 32'h0, 1'b1, F3_LB, 2'd3, 32'h7F00_0000, 1'b1, 32'h0000_007F);
    mem_xfer_check("lw",   5'd11, 1'b1, 32'h0, 1'b1, F3_LW, 2'd0, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE);
    mem_xfer_check("f3_6", 5'd12, 1'b1, 32'h0, 1'b1, 3'b110, 2'd1, 32'h8765_4321, 1'b1, 32'h8765_4321);
    mem_xfer_check("alu",  5'd13, 1'b1, 32'hDEAD_BEEF, 1'b0, F3_LB, 2'd2, 32'h1280_3456, 1'b1, 32'hDEAD_BEEF);
    mem_xfer_check("nowe", 5'd14, 1'b0, 32'h0000_0055, 1'b0, F3_LW, 2'd0, 32'h0, 1'b0, 32'h0000_0055);

    // Idle cycle: write enable drops, address/data hold
    @(posedge clk_i); #1;
    check("hold_we",   64'(rd_we_o),   64'd0);
    check("hold_addr", 64'(rd_addr_o), 64'd14);
    check("hold_data", 64'(rd_data_o), 64'h55);

    // x0 suppression still retires
    mem_xfer_check("x0", 5'd0, 1'b1, 32'h0000_1111, 1'b0, F3_LW, 2'd0, 32'h0, 1'b0, 32'h0000_1111);

    // Starvation guard: both valid, 4 mem wins then the divider is forced
    mem_drive(5'd1, 1'b1, 32'd100, 1'b0, F3_LW, 2'd0, 32'h0);
    div_valid_i = 1'b1; div_rd_addr_i = 5'd17; div_result_i = 32'h0000_1234;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("starve_mrdy", 64'(mem_ready_o), 64'd1);
      check("starve_drdy", 64'(div_ready_o), 64'd0);
      check("starve_wcnt", 64'(dut.wait_cnt), 64'(c));
      @(posedge clk_i); #1;
      exp_instret = exp_instret + 64'd1;
      check("starve_we",   64'(rd_we_o),   64'd1);
      check("starve_data", 64'(rd_data_o), 64'(100 + c));
      mem_result_i = 32'(101 + c);
    end
    #1;
    check("force_wcnt", 64'(dut.wait_cnt), 64'd4);
    check("force_drdy", 64'(div_ready_o),  64'd1);
    check("force_mrdy", 64'(mem_ready_o),  64'd0);
    @(posedge clk_i); #1;
    check("div_we",   64'(rd_we_o),   64'd1);
    check("div_addr", 64'(rd_addr_o), 64'd17);
    check("div_data", 64'(rd_data_o), 64'h1234);
    check("div_wcnt", 64'(dut.wait_cnt), 64'd0);
    check("div_ret",  instret_o, exp_instret);
    div_valid_i = 1'b0;
    #1 check("after_mrdy", 64'(mem_ready_o), 64'd1);
    @(posedge clk_i); #1;
    exp_instret = exp_instret + 64'd1;
    mem_valid_i = 1'b0;
    check("after_data", 64'(rd_data_o), 64'd104);
    check("after_ret",  instret_o, exp_instret);

    // Divider write to x0: suppressed, does not retire
    div_valid_i = 1'b1; div_rd_addr_i = 5'd0; div_result_i = 32'h0000_9999;
    #1 check("divx0_rdy", 64'(div_ready_o), 64'd1);
    @(posedge clk_i); #1;
    div_valid_i = 1'b0;
    check("divx0_we",   64'(rd_we_o),   64'd0);
    check("divx0_addr", 64'(rd_addr_o), 64'd0);
    check("divx0_ret",  instret_o, exp_instret);

    // Reset mid-flight
    mem_xfer_check("pre_rst", 5'd3, 1'b1, 32'h0000_AAAA, 1'b0, F3_LW, 2'd0, 32'h0, 1'b1, 32'h0000_AAAA);
    #1 rst_ni = 1'b0;
    #1;
    exp_instret = '0;
    check("mid_rst_we",   64'(rd_we_o),   64'd0);
    check("mid_rst_ret",  instret_o,      64'd0);
    check("mid_rst_data", 64'(rd_data_o), 64'd0);
    @(posedge clk_i); #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Back-to-back: 8 consecutive mem transfers, first write after reset included
    for (int i = 0; i < 8; i++) begin
      mem_drive(5'(i + 1), 1'b1, 32'h100 + 32'(i), 1'b0, F3_LW, 2'd0, 32'h0);
      @(posedge clk_i); #1;
      exp_instret = exp_instret + 64'd1;
      check("b2b_we",   64'(rd_we_o),   64'd1);
      check("b2b_addr", 64'(rd_addr_o), 64'(i + 1));
      check("b2b_data", 64'(rd_data_o), 64'(32'h100 + 32'(i)));
    end
    mem_valid_i = 1'b0;
    check("b2b_ret", instret_o, 64'd8);
    @(posedge clk_i); #1;
    check("b2b_end_we", 64'(rd_we_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_stage
